// File: rtl/stepper_pkg.sv
// stepper_pkg: shared definitions for the stepper-motor phase sequencer.
//   - MODE_* : encodings of the mode input (3 is reserved and behaves as HALF)
//   - state_e: controller FSM states
//   - half_step_coils(): 8-entry half-step coil table, A..D = bit 3..0
//   - step_size(): phase-index increment magnitude for a given mode and phase
package stepper_pkg;

    localparam logic [1:0] MODE_WAVE = 2'd0;
    localparam logic [1:0] MODE_FULL = 2'd1;
    localparam logic [1:0] MODE_HALF = 2'd2;

    typedef enum logic {
        StIdle = 1'b0,
        StRun  = 1'b1
    } state_e;

    // Even indices energise one coil, odd indices energise two adjacent coils.
    function automatic logic [3:0] half_step_coils(input logic [2:0] ph);
        logic [3:0] pat;
        case (ph)
            3'd0:    pat = 4'b1000;
            3'd1:    pat = 4'b1100;
            3'd2:    pat = 4'b0100;
            3'd3:    pat = 4'b0110;
            3'd4:    pat = 4'b0010;
            3'd5:    pat = 4'b0011;
            3'd6:    pat = 4'b0001;
            default: pat = 4'b1001;
        endcase
        return pat;
    endfunction

    // WAVE lives on even indices and FULL on odd ones; from the "wrong" parity
    // the first step is a single half-step so the motor realigns onto the grid.
    function automatic logic [2:0] step_size(input logic [1:0] mode, input logic [2:0] ph);
        logic [2:0] sz;
        case (mode)
            MODE_WAVE: sz = ph[0] ? 3'd1 : 3'd2;
            MODE_FULL: sz = ph[0] ? 3'd2 : 3'd1;
            default:   sz = 3'd1;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/stepper_tick_div.sv
// stepper_tick_div: step-period prescaler.
//   i_clk, i_reset : clock, asynchronous active-high reset
//   i_clear        : force the count to 0 (move start)
//   i_run          : count enable
//   i_period       : cycles per tick; 0 behaves as 1
//   o_tick         : one-cycle pulse while the count sits at P-1
module stepper_tick_div #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clear,
    input  logic             i_run,
    input  logic [DIV_W-1:0] i_period,
    output logic             o_tick
);

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] w_last;

    assign w_last = (i_period == '0) ? '0 : i_period - DIV_W'(1);
    assign o_tick = i_run && (r_cnt == w_last);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (i_clear || o_tick) begin
            r_cnt <= '0;
        end else if (i_run) begin
            r_cnt <= r_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/stepper_ctrl.sv
// stepper_ctrl: stepper-motor phase sequencer (WAVE / FULL / HALF).
//   i_clk, i_reset : clock, asynchronous active-high reset
//   i_start        : request a move (IDLE only); i_abort ends a move and wins over start
//   i_dir          : 1 = forward; i_mode: 0 WAVE, 1 FULL, 2/3 HALF
//   i_period       : cycles per step (0 as 1); i_steps: steps to issue
//   i_coil_en      : 0 blanks the coils without touching the phase
//   o_coils        : coil pattern A..D = bit 3..0
//   o_busy, o_done : move in progress / one-cycle completion pulse
//   o_steps_left   : steps still to issue; o_phase: half-step phase index
module stepper_ctrl
    import stepper_pkg::*;
#(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned DIV_W = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic             i_dir,
    input  logic [1:0]       i_mode,
    input  logic [DIV_W-1:0] i_period,
    input  logic [CNT_W-1:0] i_steps,
    input  logic             i_coil_en,
    output logic [3:0]       o_coils,
    output logic             o_busy,
    output logic             o_done,
    output logic [CNT_W-1:0] o_steps_left,
    output logic [2:0]       o_phase
);

    state_e           r_state, w_state_d;
    logic [2:0]       r_ph, w_ph_d;
    logic [CNT_W-1:0] r_steps_left, w_left_d;
    logic             r_done, w_done_d;
    logic [1:0]       r_mode, w_mode_d;
    logic             r_dir, w_dir_d;
    logic [DIV_W-1:0] r_period, w_period_d;

    logic             w_div_clear;
    logic             w_div_run;
    logic             w_tick;
    logic [2:0]       w_step;

    assign w_div_run = (r_state == StRun);

    stepper_tick_div #(
        .DIV_W (DIV_W)
    ) u_tick_div (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_clear  (w_div_clear),
        .i_run    (w_div_run),
        .i_period (r_period),
        .o_tick   (w_tick)
    );

    always_comb begin
        w_state_d   = r_state;
        w_ph_d      = r_ph;
        w_left_d    = r_steps_left;
        w_done_d    = 1'b0;
        w_mode_d    = r_mode;
        w_dir_d     = r_dir;
        w_period_d  = r_period;
        w_div_clear = 1'b0;
        w_step      = step_size(r_mode, r_ph);

        unique case (r_state)
            StIdle: begin
                if (i_start && !i_abort) begin
                    w_mode_d    = i_mode;
                    w_dir_d     = i_dir;
                    w_period_d  = i_period;
                    w_left_d    = i_steps;
                    w_div_clear = 1'b1;
                    // A zero-length move completes immediately without motion.
                    if (i_steps == '0) begin
                        w_done_d = 1'b1;
                    end else begin
                        w_state_d = StRun;
                    end
                end
            end
            StRun: begin
                // Abort takes priority over a prescaler tick on the same edge.
                if (i_abort) begin
                    w_state_d = StIdle;
                end else if (w_tick) begin
                    w_ph_d   = r_dir ? (r_ph + w_step) : (r_ph - w_step);
                    w_left_d = r_steps_left - CNT_W'(1);
                    if (r_steps_left == CNT_W'(1)) begin
                        w_state_d = StIdle;
                        w_done_d  = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= StIdle;
            r_ph         <= 3'd0;
            r_steps_left <= '0;
            r_done       <= 1'b0;
            r_mode       <= MODE_WAVE;
            r_dir        <= 1'b0;
            r_period     <= '0;
        end else begin
            r_state      <= w_state_d;
            r_ph         <= w_ph_d;
            r_steps_left <= w_left_d;
            r_done       <= w_done_d;
            r_mode       <= w_mode_d;
            r_dir        <= w_dir_d;
            r_period     <= w_period_d;
        end
    end

    assign o_coils      = i_coil_en ? half_step_coils(r_ph) : 4'b0000;
    assign o_busy       = (r_state == StRun);
    assign o_done       = r_done;
    assign o_steps_left = r_steps_left;
    assign o_phase      = r_ph;

endmodule
